// File: rtl/vmicro16_uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// vmicro16_uart_rx_pkg
// Shared definitions for the vmicro16 UART peripherals: APB register offsets,
// STATUS bit positions, receiver FSM state encodings and a parity helper.
// -----------------------------------------------------------------------------
package vmicro16_uart_rx_pkg;

    // APB word offsets
    localparam logic [1:0] UART_REG_DATA   = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;

    // STATUS register bit positions
    localparam int UART_ST_NEMPTY = 32'sd0;
    localparam int UART_ST_FULL   = 32'sd1;
    localparam int UART_ST_OVR    = 32'sd2;
    localparam int UART_ST_FERR   = 32'sd3;
    localparam int UART_ST_PERR   = 32'sd4;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_rx_state_e;

    // Even-parity bit for a data byte (XOR of all data bits)
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/vmicro16_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// vmicro16_uart_rx_fifo
// Synchronous FIFO for received bytes. Pointers carry one extra MSB so that
// full and empty are distinguishable. A push and a pop in the same cycle are
// both performed, including when the FIFO is full. A push while full without
// a pop is dropped. Pop while empty is ignored.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   i_push      write i_data (if room, or if popping this cycle)
//   i_data      byte to write
//   i_pop       remove head entry (if non-empty)
//   o_data      head entry (combinational)
//   o_full      FIFO holds DEPTH entries
//   o_empty     FIFO holds no entries
// -----------------------------------------------------------------------------
module vmicro16_uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    // When full, the slot being written is the one being popped this cycle
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array write (no reset needed: contents gated by pointers)
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/vmicro16_uart_rx.sv
// -----------------------------------------------------------------------------
// vmicro16_uart_rx
// UART receiver peripheral for the vmicro16 SoC. Deserialises frames from the
// rx pin (8N1, or 8E1 when UART_RX_PARITY_EN is defined), buffers bytes in a
// FIFO and exposes DATA / STATUS registers on an APB slave port.
// Build option:
//   UART_RX_PARITY_EN  adds an even-parity bit between data and stop bits;
//                      mismatches set STATUS.PERR and discard the byte.
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   rx           serial input, idle high, asynchronous to clk
//   S_PADDR      word select: 0 DATA, 1 STATUS, 2/3 read 0
//   S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA   APB request
//   S_PRDATA     read data (combinational), S_PREADY tied high
//   irq          FIFO non-empty or any sticky error set
// STATUS: bit0 NEMPTY, bit1 FULL, bit2 OVR, bit3 FERR, bit4 PERR (2..4 W1C)
// -----------------------------------------------------------------------------
module vmicro16_uart_rx
    import vmicro16_uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic [1:0]            S_PADDR,
    input  logic                  S_PWRITE,
    input  logic                  S_PSELx,
    input  logic                  S_PENABLE,
    input  logic [DATA_WIDTH-1:0] S_PWDATA,
    output logic [DATA_WIDTH-1:0] S_PRDATA,
    output logic                  S_PREADY,
    output logic                  irq
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    uart_rx_state_e   r_state;
    uart_rx_state_e   w_state_next;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_ovr;
    logic             r_ferr;
    logic             r_perr;
    logic             r_irq;

    logic             w_baud_tick;
    logic             w_half_tick;
    logic             w_cnt_clr;
    logic             w_shift_en;
    logic             w_push;
    logic             w_ferr_set;
    logic             w_perr_set;
    logic             w_pop;
    logic             w_st_wr;
    logic [7:0]       w_fifo_data;
    logic             w_full;
    logic             w_empty;
    logic             w_unused;
`ifdef UART_RX_PARITY_EN
    logic             r_par_bad;
    logic             w_par_en;
`endif

    assign w_baud_tick = (r_baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_half_tick = (r_baud_cnt == CNT_W'(HALF_BIT));
    assign w_pop   = S_PSELx & S_PENABLE & ~S_PWRITE & (S_PADDR == UART_REG_DATA) & ~w_empty;
    assign w_st_wr = S_PSELx & S_PENABLE & S_PWRITE & (S_PADDR == UART_REG_STATUS);
    assign S_PREADY = 1'b1;
    assign irq      = r_irq;
    assign w_unused = ^S_PWDATA;

    // Two-flop synchroniser on the asynchronous rx pin
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!r_rx_s) begin
                    w_state_next = ST_START;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_START: begin
                // A high line at mid-start-bit is a glitch, not a frame
                if (w_half_tick) begin
                    w_state_next = r_rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    w_state_next = ST_START;
                end
            end
            ST_DATA: begin
                if (w_baud_tick && (r_bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_next = ST_PARITY;
`else
                    w_state_next = ST_STOP;
`endif
                end else begin
                    w_state_next = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_baud_tick) begin
                    w_state_next = ST_STOP;
                end else begin
                    w_state_next = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                // Leave mid-stop-bit so a back-to-back start edge is caught
                if (w_baud_tick) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_STOP;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: counter control, sampling strobes, push and error flags
    always_comb begin
        w_cnt_clr  = 1'b0;
        w_shift_en = 1'b0;
        w_push     = 1'b0;
        w_ferr_set = 1'b0;
        w_perr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_en   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_cnt_clr = 1'b1;
            end
            ST_START: begin
                w_cnt_clr = w_half_tick;
            end
            ST_DATA: begin
                w_cnt_clr  = w_baud_tick;
                w_shift_en = w_baud_tick;
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                w_cnt_clr  = w_baud_tick;
                w_par_en   = w_baud_tick;
                w_perr_set = w_baud_tick & (r_rx_s != even_parity(r_shift));
            end
`endif
            ST_STOP: begin
                w_cnt_clr  = w_baud_tick;
                w_ferr_set = w_baud_tick & ~r_rx_s;
`ifdef UART_RX_PARITY_EN
                w_push     = w_baud_tick & r_rx_s & ~r_par_bad;
`else
                w_push     = w_baud_tick & r_rx_s;
`endif
            end
            default: begin
                w_cnt_clr = 1'b1;
            end
        endcase
    end

    // Baud/bit counters and data shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
        end else begin
            r_baud_cnt <= w_cnt_clr ? '0 : (r_baud_cnt + CNT_W'(1));
            if (r_state == ST_START) begin
                r_bit_cnt <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_shift_en) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity result held until the stop bit decides whether to push
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par_bad <= 1'b0;
        end else if (r_state == ST_START) begin
            r_par_bad <= 1'b0;
        end else if (w_par_en) begin
            r_par_bad <= (r_rx_s != even_parity(r_shift));
        end
    end
`endif

    // Sticky error bits: a set in the same cycle as a W1C clear wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            if (w_push && w_full && !w_pop) begin
                r_ovr <= 1'b1;
            end else if (w_st_wr && S_PWDATA[UART_ST_OVR]) begin
                r_ovr <= 1'b0;
            end
            if (w_ferr_set) begin
                r_ferr <= 1'b1;
            end else if (w_st_wr && S_PWDATA[UART_ST_FERR]) begin
                r_ferr <= 1'b0;
            end
            if (w_perr_set) begin
                r_perr <= 1'b1;
            end else if (w_st_wr && S_PWDATA[UART_ST_PERR]) begin
                r_perr <= 1'b0;
            end
        end
    end

    // Registered interrupt level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= ~w_empty | r_ovr | r_ferr | r_perr;
        end
    end

    // APB read mux
    always_comb begin
        S_PRDATA = '0;
        if (S_PSELx && !S_PWRITE) begin
            case (S_PADDR)
                UART_REG_DATA: begin
                    S_PRDATA[7:0] = w_empty ? 8'h00 : w_fifo_data;
                end
                UART_REG_STATUS: begin
                    S_PRDATA[UART_ST_NEMPTY] = ~w_empty;
                    S_PRDATA[UART_ST_FULL]   = w_full;
                    S_PRDATA[UART_ST_OVR]    = r_ovr;
                    S_PRDATA[UART_ST_FERR]   = r_ferr;
                    S_PRDATA[UART_ST_PERR]   = r_perr;
                end
                default: begin
                    S_PRDATA = '0;
                end
            endcase
        end else begin
            S_PRDATA = '0;
        end
    end

    vmicro16_uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_vmicro16_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_vmicro16_uart_rx
// Directed self-checking bench for vmicro16_uart_rx at 50 MHz / 115200 baud
// (434 clocks per bit) with an 8-entry FIFO. Also covers UART_RX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_vmicro16_uart_rx;

    localparam int CLK_HZ     = 50_000_000;
    localparam int BAUD       = 115200;
    localparam int FIFO_DEPTH = 8;
    localparam int DATA_WIDTH = 16;
    localparam int CPB        = CLK_HZ / BAUD;
    localparam int HALF       = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NSTAGES    = 10;
`else
    localparam int NSTAGES    = 9;
`endif
    // Negedges from start-bit drive to APB setup so the access phase
    // covers the clock edge on which the stop bit is sampled and pushed
    localparam int PUSH_LEAD  = 2 + HALF + CPB * NSTAGES;

    logic                  clk;
    logic                  reset;
    logic                  rx;
    logic [1:0]            S_PADDR;
    logic                  S_PWRITE;
    logic                  S_PSELx;
    logic                  S_PENABLE;
    logic [DATA_WIDTH-1:0] S_PWDATA;
    logic [DATA_WIDTH-1:0] S_PRDATA;
    logic                  S_PREADY;
    logic                  irq;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] rd;

    vmicro16_uart_rx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .S_PADDR   (S_PADDR),
        .S_PWRITE  (S_PWRITE),
        .S_PSELx   (S_PSELx),
        .S_PENABLE (S_PENABLE),
        .S_PWDATA  (S_PWDATA),
        .S_PRDATA  (S_PRDATA),
        .S_PREADY  (S_PREADY),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // All bus/line tasks start and end on a negedge
    task automatic apb_read(input logic [1:0] addr, output logic [15:0] data);
        S_PSELx = 1'b1; S_PWRITE = 1'b0; S_PADDR = addr; S_PENABLE = 1'b0;
        @(negedge clk);
        data = S_PRDATA;
        S_PENABLE = 1'b1;
        @(negedge clk);
        S_PSELx = 1'b0; S_PENABLE = 1'b0;
    endtask

    task automatic apb_write(input logic [1:0] addr, input logic [15:0] data);
        S_PSELx = 1'b1; S_PWRITE = 1'b1; S_PADDR = addr; S_PWDATA = data; S_PENABLE = 1'b0;
        @(negedge clk);
        S_PENABLE = 1'b1;
        @(negedge clk);
        S_PSELx = 1'b0; S_PENABLE = 1'b0; S_PWRITE = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] addr, input logic [15:0] exp);
        logic [15:0] d;
        apb_read(addr, d);
        check_eq(tag, {16'h0000, d}, {16'h0000, exp});
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_flip);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^data) ^ par_flip;
        repeat (CPB) @(negedge clk);
`endif
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        reset = 1'b1; rx = 1'b1;
        S_PADDR = 2'd1; S_PWRITE = 1'b0; S_PSELx = 1'b1; S_PENABLE = 1'b0; S_PWDATA = 16'h0000;
        repeat (3) @(negedge clk);
        check_eq("reset_prdata", {16'h0000, S_PRDATA}, 32'h0);
        check_eq("reset_irq", {31'b0, irq}, 32'h0);
        check_eq("pready", {31'b0, S_PREADY}, 32'h1);
        S_PSELx = 1'b0;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        read_check("reset_status", 2'd1, 16'h0000);

        // 1: single byte, reserved addresses, ignored DATA write
        send_frame(8'hA5, 1'b1, 1'b0);
        read_check("t1_status", 2'd1, 16'h0001);
        check_eq("t1_irq", {31'b0, irq}, 32'h1);
        read_check("t1_addr2", 2'd2, 16'h0000);
        read_check("t1_addr3", 2'd3, 16'h0000);
        apb_write(2'd0, 16'hFFFF);
        read_check("t1_status_after_wr", 2'd1, 16'h0001);
        read_check("t1_data", 2'd0, 16'h00A5);
        read_check("t1_status_empty", 2'd1, 16'h0000);
        check_eq("t1_irq_clear", {31'b0, irq}, 32'h0);
        read_check("t1_empty_read", 2'd0, 16'h0000);
        read_check("t1_status_nochg", 2'd1, 16'h0000);

        // 2: nine back-to-back bytes into an 8-deep FIFO
        for (int b = 0; b < 9; b++) begin
            v = 8'(b);
            send_frame(v, 1'b1, 1'b0);
        end
        read_check("t2_status_ovr", 2'd1, 16'h0007);
        check_eq("t2_irq", {31'b0, irq}, 32'h1);
        apb_write(2'd1, 16'h0004);
        read_check("t2_status_w1c", 2'd1, 16'h0003);

        // 6: push into the full FIFO on the same edge as a DATA pop
        fork
            send_frame(8'h09, 1'b1, 1'b0);
            begin
                repeat (PUSH_LEAD) @(negedge clk);
                apb_read(2'd0, rd);
                check_eq("t6_pop_oldest", {16'h0000, rd}, 32'h0000);
            end
        join
        read_check("t6_status_full", 2'd1, 16'h0003);
        for (int i = 1; i < 9; i++) begin
            read_check("t6_drain", 2'd0, (i < 8) ? 16'(i) : 16'h0009);
        end
        read_check("t6_status_end", 2'd1, 16'h0000);

        // 3: framing error
        send_frame(8'h3C, 1'b0, 1'b0);
        read_check("t3_status_ferr", 2'd1, 16'h0008);
        check_eq("t3_irq", {31'b0, irq}, 32'h1);
        apb_write(2'd1, 16'h0008);
        read_check("t3_status_clr", 2'd1, 16'h0000);
        check_eq("t3_irq_clear", {31'b0, irq}, 32'h0);
        repeat (CPB) @(negedge clk);

        // 4: short low glitch, then a clean frame
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        read_check("t4_status_glitch", 2'd1, 16'h0000);
        send_frame(8'h5A, 1'b1, 1'b0);
        read_check("t4_data", 2'd0, 16'h005A);

        // 5: reset during data bit 4, then a clean frame
        v = 8'h81;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = v[i];
            repeat (CPB) @(negedge clk);
        end
        rx = v[4];
        repeat (200) @(negedge clk);
        reset = 1'b1; rx = 1'b1;
        S_PSELx = 1'b1; S_PADDR = 2'd0;
        repeat (3) @(negedge clk);
        check_eq("t5_reset_prdata", {16'h0000, S_PRDATA}, 32'h0);
        check_eq("t5_reset_irq", {31'b0, irq}, 32'h0);
        S_PSELx = 1'b0;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        read_check("t5_status", 2'd1, 16'h0000);
        send_frame(8'h81, 1'b1, 1'b0);
        read_check("t5_data", 2'd0, 16'h0081);
        read_check("t5_status_end", 2'd1, 16'h0000);

`ifdef UART_RX_PARITY_EN
        // Parity error: 0x01 needs parity 1; send 0
        send_frame(8'h01, 1'b1, 1'b1);
        read_check("par_status", 2'd1, 16'h0010);
        read_check("par_data", 2'd0, 16'h0000);
        apb_write(2'd1, 16'h0010);
        read_check("par_clr", 2'd1, 16'h0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
